// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle for the sequential restoring divider.
// The requester drives start and operands; the divider returns status and results.
interface seq_restoring_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
// Results are registered separately from the working regs and held until rewritten.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_restoring_divider_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH+1:0] r_sh;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   r_new;
   logic [WIDTH-1:0] q_new;

   // Trial subtract as R + ~D + 1; a set msb means negative, so restore
   always_comb begin
      r_sh  = {r_q, q_q[WIDTH-1]};
      trial = r_sh + ~{2'b00, d_q} + (WIDTH+2)'(1);
      r_new = trial[WIDTH+1] ? r_sh[WIDTH:0] : trial[WIDTH:0];
      q_new = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CALC;
         CALC:    if (d_q == '0 || cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy        = (state_q != IDLE);
      bus.done        = (state_q == DONE);
      bus.quotient    = quo_q;
      bus.remainder   = rem_q;
      bus.div_by_zero = dbz_q;
   end

   always_comb begin
      cnt_d = cnt_q;
      r_d   = r_q;
      q_d   = q_q;
      d_d   = d_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dbz_d = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               q_d   = bus.dividend;
               d_d   = bus.divisor;
               r_d   = '0;
               cnt_d = '0;
               dbz_d = 1'b0;
            end
         end
         CALC: begin
            // Zero divisor: Q still holds the dividend untouched
            if (d_q == '0) begin
               quo_d = '1;
               rem_d = q_q;
               dbz_d = 1'b1;
            end else begin
               r_d   = r_new;
               q_d   = q_new;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  quo_d = q_new;
                  rem_d = r_new[WIDTH-1:0];
               end
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed vectors, a full
// operand sweep, held-start pacing and mid-operation reset.
module tb_seq_restoring_divider;
   localparam int W = 4;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
      int           acc;
      int           a;
      int           b;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   seq_restoring_divider_if #(.WIDTH(W)) dif ();

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int a, input int b, input logic [W-1:0] q,
                       input logic [W-1:0] r, input logic dbz);
      exp_t e;
      e.q   = q;
      e.r   = r;
      e.dbz = dbz;
      e.lat = dbz ? 2 : W + 1;
      e.acc = cyc;
      e.a   = a;
      e.b   = b;
      sb.push_back(e);
   endtask

   // Monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (dif.done) begin
         n_cmp = n_cmp + 1;
         if (sb.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL stray_done: got q=%0d r=%0d dbz=%0d, required no done",
                     dif.quotient, dif.remainder, dif.div_by_zero);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (dif.quotient !== e.q || dif.remainder !== e.r ||
                dif.div_by_zero !== e.dbz || (cyc - e.acc + 1) != e.lat) begin
               n_bad = n_bad + 1;
               $display("FAIL div %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d, required q=%0d r=%0d dbz=%0d lat=%0d",
                        e.a, e.b, dif.quotient, dif.remainder, dif.div_by_zero,
                        cyc - e.acc + 1, e.q, e.r, e.dbz, e.lat);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] req);
      n_cmp = n_cmp + 1;
      if (got !== req) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!dif.busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL idle_timeout: got busy=1, required busy=0");
      end
   endtask

   // Called at a negedge with the divider idle; returns at an idle negedge
   task automatic issue(input int a, input int b, input logic [W-1:0] q,
                        input logic [W-1:0] r, input logic dbz);
      dif.start    = 1'b1;
      dif.dividend = W'(a);
      dif.divisor  = W'(b);
      @(posedge clk);
      #1;
      push(a, b, q, r, dbz);
      dif.start    = 1'b0;
      dif.dividend = '1;
      dif.divisor  = '0;
      wait_idle();
   endtask

   initial begin
      bit ok;
      cyc          = 0;
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      dif.start    = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs",
            {dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder},
            '0);

      // 13/3 with a busy check the cycle after start
      dif.start    = 1'b1;
      dif.dividend = 4'd13;
      dif.divisor  = 4'd3;
      @(posedge clk);
      #1;
      push(13, 3, 4'd4, 4'd1, 1'b0);
      dif.start = 1'b0;
      @(negedge clk);
      check("busy_after_start", dif.busy, 1'b1);
      wait_idle();

      issue(15, 1, 4'd15, 4'd0, 1'b0);
      issue(15, 15, 4'd1, 4'd0, 1'b0);
      issue(2, 9, 4'd0, 4'd2, 1'b0);
      issue(0, 5, 4'd0, 4'd0, 1'b0);
      issue(7, 0, 4'd15, 4'd7, 1'b1);
      issue(6, 2, 4'd3, 4'd0, 1'b0);
      issue(12, 5, 4'd2, 4'd2, 1'b0);

      // start held high: garbage operands while busy, incl. the done cycle
      dif.start    = 1'b1;
      dif.dividend = 4'd9;
      dif.divisor  = 4'd2;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         push(9, 2, 4'd4, 4'd1, 1'b0);
         if (i < 2) begin
            @(negedge clk);
            dif.dividend = 4'd15;
            dif.divisor  = 4'd0;
            repeat (5) @(negedge clk);
            dif.dividend = 4'd9;
            dif.divisor  = 4'd2;
         end
      end
      dif.start = 1'b0;
      wait_idle();

      // reset during the third CALC cycle of 14/3
      dif.start    = 1'b1;
      dif.dividend = 4'd14;
      dif.divisor  = 4'd3;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_calc_reset",
            {dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder},
            '0);
      repeat (8) @(negedge clk);
      issue(14, 3, 4'd4, 4'd2, 1'b0);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) issue(a, b, 4'd15, W'(a), 1'b1);
            else        issue(a, b, W'(a / b), W'(a % b), 1'b0);
         end
      end

      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("scoreboard_drained", ok, 1'b1);
      repeat (4) @(negedge clk);
      check("results_held",
            {dif.quotient, dif.remainder, dif.div_by_zero}, {4'd1, 4'd0, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
